// File: rtl/fazyrv_alu_seq.sv
// Sequencer that feeds 32-bit operands chunk by chunk into an external chunked ALU
// and reassembles the result; one operation in flight, valid/ready on both sides.
module fazyrv_alu_seq #(
  parameter int CHUNKSIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [31:0]          op_a_i,
  input  logic [31:0]          op_b_i,
  input  logic [3:0]           op_i,
  output logic                 lsb_o,
  output logic                 msb_o,
  output logic [CHUNKSIZE-1:0] rs_a_o,
  output logic [CHUNKSIZE-1:0] rs_b_o,
  input  logic [CHUNKSIZE-1:0] alu_res_i,
  input  logic                 alu_cmp_i,
  output logic                 sel_arith_o,
  output logic                 en_a_o,
  output logic                 op_sub_o,
  output logic                 op_xor_o,
  output logic                 op_and_o,
  output logic                 cmp_signd_o,
  output logic                 cmp_eq_o,
  output logic                 cmp_keep_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_data_o,
  output logic                 rsp_cmp_o
);

  localparam int ITER = 32 / CHUNKSIZE;
  localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_op;
  logic [5:0]  r_cnt;
  logic [31:0] r_sh;
  logic [31:0] r_data;
  logic        r_cmp;
  logic        r_valid;
  logic        r_lsb;
  logic        r_msb;
  logic [6:0]  r_ctrl;
  logic [31:0] w_res_next;
  logic        w_is_cmp;

  // Control bundle order: {sel_arith, en_a, op_sub, op_xor, op_and, cmp_signd, cmp_eq}
  function automatic logic [6:0] decode(input logic [3:0] op);
    case (op)
      4'd1:    decode = 7'b1100000;
      4'd2:    decode = 7'b1110000;
      4'd3:    decode = 7'b0100010;
      4'd4:    decode = 7'b0100000;
      4'd5:    decode = 7'b0100001;
      4'd6:    decode = 7'b0101000;
      4'd7:    decode = 7'b0100000;
      4'd8:    decode = 7'b0100100;
      default: decode = 7'b1000000;
    endcase
  endfunction

  // New chunk enters at the top; after ITER shifts the LSB chunk sits at bit 0.
  assign w_res_next = 32'({alu_res_i, r_sh} >> CHUNKSIZE);
  assign w_is_cmp   = (r_op == 4'd3) || (r_op == 4'd4) || (r_op == 4'd5);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_cmp   <= 1'b0;
      r_valid <= 1'b0;
      r_lsb   <= 1'b0;
      r_msb   <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_a     <= op_a_i;
            r_b     <= op_b_i;
            r_op    <= op_i;
            r_cnt   <= CNT_LAST;
            r_ctrl  <= decode(op_i);
            r_lsb   <= 1'b1;
            r_msb   <= (ITER == 1);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> CHUNKSIZE;
          r_b   <= r_b >> CHUNKSIZE;
          r_sh  <= w_res_next;
          r_lsb <= 1'b0;
          if (r_cnt == 6'd0) begin
            r_data  <= w_res_next;
            r_cmp   <= alu_cmp_i & w_is_cmp;
            r_ctrl  <= '0;
            r_msb   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
            r_msb <= (r_cnt == 6'd1);
          end
        end
        S_DONE: begin
          if (rsp_ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ready is held low for the whole reset pulse, not just until the next edge.
  assign req_ready_o = (r_state == S_IDLE) && !rst_i;
  assign lsb_o       = r_lsb;
  assign msb_o       = r_msb;
  assign rs_a_o      = r_a[CHUNKSIZE-1:0];
  assign rs_b_o      = r_b[CHUNKSIZE-1:0];
  assign {sel_arith_o, en_a_o, op_sub_o, op_xor_o, op_and_o, cmp_signd_o, cmp_eq_o} = r_ctrl;
  assign cmp_keep_o  = 1'b0;
  assign rsp_valid_o = r_valid;
  assign rsp_data_o  = r_data;
  assign rsp_cmp_o   = r_cmp;

endmodule

// File: tb/tb_fazyrv_alu_seq.sv
// Directed bench: two sequencer instances (8-bit and 32-bit chunks), each driving a
// behavioural chunked ALU; vector table plus stall and mid-operation reset sequences.
module tb_fazyrv_alu_seq;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        e;
    logic        cmp;
  } alu_o_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        c;
    logic [7:0]  ctl;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_v;
  logic [31:0] a_in, b_in;
  logic [3:0]  op_in;
  logic        rsp_rdy;
  int          sel;
  int          total = 0;
  int          bad = 0;

  logic        rdy8, lsb8, msb8, val8, rcmp8, cmp8, c8, e8;
  logic [7:0]  rsa8, rsb8, res8, ctl8;
  logic [31:0] data8;
  logic        rdy32, lsb32, msb32, val32, rcmp32, cmp32, c32, e32;
  logic [31:0] rsa32, rsb32, res32, data32;
  logic [7:0]  ctl32;
  alu_o_t      m8, m32;

  fazyrv_alu_seq #(.CHUNKSIZE(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_v && sel == 0), .req_ready_o(rdy8),
    .op_a_i(a_in), .op_b_i(b_in), .op_i(op_in), .lsb_o(lsb8), .msb_o(msb8),
    .rs_a_o(rsa8), .rs_b_o(rsb8), .alu_res_i(res8), .alu_cmp_i(cmp8),
    .sel_arith_o(ctl8[7]), .en_a_o(ctl8[6]), .op_sub_o(ctl8[5]), .op_xor_o(ctl8[4]),
    .op_and_o(ctl8[3]), .cmp_signd_o(ctl8[2]), .cmp_eq_o(ctl8[1]), .cmp_keep_o(ctl8[0]),
    .rsp_valid_o(val8), .rsp_ready_i(rsp_rdy && sel == 0), .rsp_data_o(data8), .rsp_cmp_o(rcmp8)
  );

  fazyrv_alu_seq #(.CHUNKSIZE(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_v && sel == 1), .req_ready_o(rdy32),
    .op_a_i(a_in), .op_b_i(b_in), .op_i(op_in), .lsb_o(lsb32), .msb_o(msb32),
    .rs_a_o(rsa32), .rs_b_o(rsb32), .alu_res_i(res32), .alu_cmp_i(cmp32),
    .sel_arith_o(ctl32[7]), .en_a_o(ctl32[6]), .op_sub_o(ctl32[5]), .op_xor_o(ctl32[4]),
    .op_and_o(ctl32[3]), .cmp_signd_o(ctl32[2]), .cmp_eq_o(ctl32[1]), .cmp_keep_o(ctl32[0]),
    .rsp_valid_o(val32), .rsp_ready_i(rsp_rdy && sel == 1), .rsp_data_o(data32), .rsp_cmp_o(rcmp32)
  );

  // Behavioural chunked ALU: carry and equality chains restart on lsb.
  function automatic alu_o_t alu_step(input int cw, input logic [31:0] a, input logic [31:0] b,
                                      input logic [7:0] ctl, input logic lsb,
                                      input logic c_reg, input logic e_reg);
    alu_o_t o;
    logic [63:0] mask, ae, bm, be, s;
    logic sub_eff, cin, lt_s;
    mask    = (64'd1 << cw) - 64'd1;
    bm      = {32'b0, b} & mask;
    ae      = ctl[6] ? ({32'b0, a} & mask) : 64'd0;
    sub_eff = ctl[5] | ~ctl[7];
    be      = sub_eff ? (~{32'b0, b} & mask) : bm;
    cin     = lsb ? sub_eff : c_reg;
    s       = ae + be + {63'b0, cin};
    o.c     = s[cw];
    o.e     = (lsb ? 1'b1 : e_reg) & (ae == bm);
    lt_s    = (a[cw-1] != b[cw-1]) ? a[cw-1] : ~o.c;
    o.cmp   = ctl[1] ? o.e : (ctl[2] ? lt_s : ~o.c);
    if (ctl[7])      o.res = s[31:0];
    else if (ctl[4]) o.res = a ^ b;
    else if (ctl[3]) o.res = a & b;
    else             o.res = a | b;
    o.res = o.res & mask[31:0];
    return o;
  endfunction

  always_comb begin
    m8    = alu_step(8, {24'b0, rsa8}, {24'b0, rsb8}, ctl8, lsb8, c8, e8);
    res8  = m8.res[7:0];
    cmp8  = m8.cmp;
    m32   = alu_step(32, rsa32, rsb32, ctl32, lsb32, c32, e32);
    res32 = m32.res;
    cmp32 = m32.cmp;
  end

  always @(posedge clk) begin
    c8  <= m8.c;  e8  <= m8.e;
    c32 <= m32.c; e32 <= m32.e;
  end

  logic        s_rdy, s_lsb, s_msb, s_val, s_cmp;
  logic [31:0] s_rsa, s_rsb, s_data;
  logic [7:0]  s_ctl;
  always_comb begin
    if (sel == 0) begin
      s_rdy = rdy8; s_lsb = lsb8; s_msb = msb8; s_val = val8; s_cmp = rcmp8;
      s_rsa = {24'b0, rsa8}; s_rsb = {24'b0, rsb8}; s_data = data8; s_ctl = ctl8;
    end else begin
      s_rdy = rdy32; s_lsb = lsb32; s_msb = msb32; s_val = val32; s_cmp = rcmp32;
      s_rsa = rsa32; s_rsb = rsb32; s_data = data32; s_ctl = ctl32;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Issues one request, records the per-cycle chunk streams, optionally stalls in DONE.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int iter, input int hold,
                        output logic [31:0] data, output logic cmp, output int lat,
                        output logic [31:0] asa, output logic [31:0] asb, output logic [7:0] ctl0,
                        output logic [31:0] lsbm, output logic [31:0] msbm);
    int w;
    int idx;
    int chunk;
    chunk = 32 / iter;
    @(negedge clk);
    w = 0;
    while (!s_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!s_rdy) check("req_ready_timeout", 32'(s_rdy), 32'd1);
    a_in = a; b_in = b; op_in = op; req_v = 1'b1;
    @(negedge clk);
    req_v = 1'b0;
    idx = 0; asa = '0; asb = '0; lsbm = '0; msbm = '0; ctl0 = '0;
    while (!s_val && idx < 40) begin
      if (idx < iter) begin
        asa |= s_rsa << (chunk * idx);
        asb |= s_rsb << (chunk * idx);
      end
      if (idx < 32) begin
        lsbm |= 32'(s_lsb) << idx;
        msbm |= 32'(s_msb) << idx;
      end
      if (idx == 0) ctl0 = s_ctl;
      idx++;
      @(negedge clk);
    end
    lat = idx;
    data = s_data;
    cmp = s_cmp;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(s_val), 32'd1);
      check("stall_data", s_data, data);
      check("stall_req_ready", 32'(s_rdy), 32'd0);
      check("stall_ctrl_idle", {22'b0, s_lsb, s_msb, s_ctl}, 32'd0);
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
  endtask

  vec_t        tv[17];
  logic [31:0] d, asa, asb, lm, mm;
  logic        c;
  logic [7:0]  ctl0;
  int          lat;
  int          seen;

  initial begin
    tv[0]  = '{4'd1,  32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 8'hC0};
    tv[1]  = '{4'd2,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 8'hE0};
    tv[2]  = '{4'd3,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b1, 8'h44};
    tv[3]  = '{4'd4,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 8'h40};
    tv[4]  = '{4'd5,  32'h00001234, 32'h00001234, 32'h00001234, 1'b1, 8'h42};
    tv[5]  = '{4'd5,  32'h00001234, 32'h00001235, 32'h00001235, 1'b0, 8'h42};
    tv[6]  = '{4'd12, 32'hDEADBEEF, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 8'h80};
    tv[7]  = '{4'd0,  32'h12345678, 32'h87654321, 32'h87654321, 1'b0, 8'h80};
    tv[8]  = '{4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 8'h50};
    tv[9]  = '{4'd7,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 8'h40};
    tv[10] = '{4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 8'h48};
    tv[11] = '{4'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 8'hC0};
    tv[12] = '{4'd3,  32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 8'h44};
    tv[13] = '{4'd4,  32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 8'h40};
    tv[14] = '{4'd1,  32'h44332211, 32'h88776655, 32'hCCAA8866, 1'b0, 8'hC0};
    tv[15] = '{4'd2,  32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 8'hE0};
    tv[16] = '{4'd15, 32'h00000001, 32'h00000002, 32'h00000002, 1'b0, 8'h80};

    rst = 1'b1; req_v = 1'b0; rsp_rdy = 1'b0; a_in = '0; b_in = '0; op_in = '0; sel = 0;
    #12;
    check("reset_req_ready_low", 32'(s_rdy), 32'd0);
    check("reset_valid", 32'(s_val), 32'd0);
    check("reset_data", s_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_req_ready", 32'(s_rdy), 32'd1);

    for (int i = 0; i < 17; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, 4, 0, d, c, lat, asa, asb, ctl0, lm, mm);
      check($sformatf("v%0d_data", i), d, tv[i].d);
      check($sformatf("v%0d_cmp", i), 32'(c), 32'(tv[i].c));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_chunks_a", i), asa, tv[i].a);
      check($sformatf("v%0d_chunks_b", i), asb, tv[i].b);
      check($sformatf("v%0d_ctrl", i), 32'(ctl0), 32'(tv[i].ctl));
      check($sformatf("v%0d_lsb", i), lm, 32'h1);
      check($sformatf("v%0d_msb", i), mm, 32'h8);
    end

    // DONE stall: response must hold, then handshake returns to IDLE and keeps the result
    run_op(4'd1, 32'h00000010, 32'h00000020, 4, 5, d, c, lat, asa, asb, ctl0, lm, mm);
    check("stall_result", d, 32'h00000030);
    check("post_hs_req_ready", 32'(s_rdy), 32'd1);
    check("post_hs_valid", 32'(s_val), 32'd0);
    check("post_hs_data_held", s_data, 32'h00000030);

    // Reset mid-RUN with counter at 2
    @(negedge clk);
    a_in = 32'h01020304; b_in = 32'h10203040; op_in = 4'd1; req_v = 1'b1;
    @(negedge clk);
    req_v = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(s_rdy), 32'd0);
    check("rst_strobes_ctrl", {22'b0, s_lsb, s_msb, s_ctl}, 32'd0);
    check("rst_rs_a", s_rsa, 32'd0);
    check("rst_rs_b", s_rsb, 32'd0);
    check("rst_data", s_data, 32'd0);
    check("rst_valid_cmp", {30'b0, s_val, s_cmp}, 32'd0);
    #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (s_val) seen++;
    end
    check("rst_no_response", 32'(seen), 32'd0);
    check("rst_ready_after", 32'(s_rdy), 32'd1);
    run_op(4'd1, 32'h01020304, 32'h10203040, 4, 0, d, c, lat, asa, asb, ctl0, lm, mm);
    check("after_rst_data", d, 32'h11223344);
    check("after_rst_latency", 32'(lat), 32'd4);

    // Single-chunk configuration
    sel = 1;
    run_op(4'd2, 32'h00000005, 32'h00000007, 1, 0, d, c, lat, asa, asb, ctl0, lm, mm);
    check("c32_sub_data", d, 32'hFFFFFFFE);
    check("c32_latency", 32'(lat), 32'd1);
    check("c32_lsb", lm, 32'h1);
    check("c32_msb", mm, 32'h1);
    check("c32_ctrl", 32'(ctl0), 32'h000000E0);
    check("c32_rs_a", asa, 32'h00000005);
    run_op(4'd3, 32'hFFFFFFFF, 32'h00000001, 1, 0, d, c, lat, asa, asb, ctl0, lm, mm);
    check("c32_lt_cmp", 32'(c), 32'd1);
    run_op(4'd1, 32'hFFFFFFFF, 32'h00000001, 1, 0, d, c, lat, asa, asb, ctl0, lm, mm);
    check("c32_add_wrap", d, 32'h00000000);
    check("c32_add_cmp", 32'(c), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
